// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encoding, datapath width, slot states and
// an op-code legality helper. Also used by the instruction decoder.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_NOT = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_ASR = 4'd4,
        OP_SHL = 4'd5,
        OP_BEQ = 4'd6,
        OP_BNE = 4'd7,
        OP_XOR = 4'd8
    } alu_op_t;

    localparam int ALU_W = 16;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Codes above OP_XOR have no defined behaviour.
    function automatic logic is_legal_op(input logic [3:0] op);
        return (op <= 4'd8);
    endfunction

endpackage

// File: rtl/alu.sv
// 16-bit combinational ALU. Branch ops test operand a against zero.
// Undefined op codes drive f, ovf and take_branch to all-ones.
module alu
    import alu_pkg::*;
(
    input  logic [3:0]       op,
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    output logic [ALU_W-1:0] f,
    output logic             ovf,
    output logic             take_branch
);

    // Operation decode; the shift amount is the full b operand.
    always_comb begin
        f           = '0;
        ovf         = 1'b0;
        take_branch = 1'b0;
        case (op)
            OP_ADD: begin
                f   = a + b;
                ovf = (a[ALU_W-1] == b[ALU_W-1]) && (f[ALU_W-1] != a[ALU_W-1]);
            end
            OP_NOT: f = ~a;
            OP_AND: f = a & b;
            OP_OR:  f = a | b;
            OP_ASR: f = $signed(a) >>> b;
            OP_SHL: f = a << b;
            OP_BEQ: take_branch = (a == '0);
            OP_BNE: take_branch = (a != '0);
            OP_XOR: f = a ^ b;
            default: begin
                f           = '1;
                ovf         = 1'b1;
                take_branch = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N    = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    // Walk offsets 0..N-1 from ptr; the first requesting index wins.
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] &&
                    ((i == int'(ptr) + k) || (i == int'(ptr) + k - N))) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between N_REQ requesters with round-robin arbitration.
// Each requester owns a one-entry response slot; a granted op is computed
// in its grant cycle and lands in the slot on the next edge.
//
// Slot states:
//   state      | meaning
//   SLOT_EMPTY | no result held, requester may be granted
//   SLOT_FULL  | result held on rsp_*; refill allowed only while consumed
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*4-1:0]     req_op,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [N_REQ*WIDTH-1:0] rsp_f,
    output logic [N_REQ-1:0]       rsp_ovf,
    output logic [N_REQ-1:0]       rsp_branch,
    output logic [N_REQ-1:0]       rsp_illegal,
    output logic [7:0]             illegal_cnt
);

    localparam int PTR_W = (N_REQ > 2) ? 2 : 1;

    if (WIDTH != ALU_W) begin : g_bad_width
        $error("alu_arbiter: WIDTH must equal ALU_W (16)");
    end
    if (N_REQ < 2 || N_REQ > 4) begin : g_bad_nreq
        $error("alu_arbiter: N_REQ must be in 2..4");
    end

    logic [N_REQ-1:0] full;
    logic [N_REQ-1:0] can_accept;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] grant;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] grant_idx;

    logic [3:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_legal;

    logic [WIDTH-1:0] alu_f;
    logic             alu_ovf;
    logic             alu_branch;
    logic [WIDTH-1:0] res_f;
    logic             res_ovf;
    logic             res_branch;

    // A full slot can take new data in the same cycle it is consumed.
    assign can_accept = ~full | rsp_ready;
    assign eligible   = req_valid & can_accept & {N_REQ{~rst}};
    assign req_ready  = grant;

    rr_arbiter #(.N(N_REQ), .PTR_W(PTR_W)) u_rr (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Route the granted requester's operation to the shared ALU.
    always_comb begin
        sel_op    = '0;
        sel_a     = '0;
        sel_b     = '0;
        grant_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_op    = req_op[i*4 +: 4];
                sel_a     = req_a[i*WIDTH +: WIDTH];
                sel_b     = req_b[i*WIDTH +: WIDTH];
                grant_idx = PTR_W'(i);
            end
        end
    end

    assign sel_legal = is_legal_op(sel_op);

    alu u_alu (
        .op          (sel_op),
        .a           (sel_a),
        .b           (sel_b),
        .f           (alu_f),
        .ovf         (alu_ovf),
        .take_branch (alu_branch)
    );

    // The ALU's default path drives all-ones; illegal results are zeroed.
    assign res_f      = sel_legal ? alu_f      : '0;
    assign res_ovf    = sel_legal ? alu_ovf    : 1'b0;
    assign res_branch = sel_legal ? alu_branch : 1'b0;

    // Round-robin pointer moves past the winner; holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (|grant) begin
            rr_ptr <= (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Saturating count of accepted illegal ops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if ((|grant) && !sel_legal && (illegal_cnt != 8'hFF)) begin
            illegal_cnt <= illegal_cnt + 8'd1;
        end
    end

    for (genvar i = 0; i < N_REQ; i++) begin : g_slot
        slot_state_t      state;
        slot_state_t      state_nxt;
        logic [WIDTH-1:0] f_q;
        logic             ovf_q;
        logic             branch_q;
        logic             illegal_q;
        logic             consume;

        assign consume = (state == SLOT_FULL) && rsp_ready[i];

        // Slot state register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= SLOT_EMPTY;
            end else begin
                state <= state_nxt;
            end
        end

        // Grant fills the slot; consume without a refill empties it.
        always_comb begin
            state_nxt = state;
            case (state)
                SLOT_EMPTY: if (grant[i]) state_nxt = SLOT_FULL;
                SLOT_FULL:  if (consume && !grant[i]) state_nxt = SLOT_EMPTY;
            endcase
        end

        // Result capture; contents only change on a grant to this slot.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                f_q       <= '0;
                ovf_q     <= 1'b0;
                branch_q  <= 1'b0;
                illegal_q <= 1'b0;
            end else if (grant[i]) begin
                f_q       <= res_f;
                ovf_q     <= res_ovf;
                branch_q  <= res_branch;
                illegal_q <= ~sel_legal;
            end
        end

        assign full[i]                   = (state == SLOT_FULL);
        assign rsp_valid[i]              = (state == SLOT_FULL);
        assign rsp_f[i*WIDTH +: WIDTH]   = f_q;
        assign rsp_ovf[i]                = ovf_q;
        assign rsp_branch[i]             = branch_q;
        assign rsp_illegal[i]            = illegal_q;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a per-requester response scoreboard.
module tb_alu_arbiter;

    localparam int N = 2;
    localparam int W = 16;

    typedef struct packed {
        logic [15:0] f;
        logic        ovf;
        logic        br;
        logic        ill;
    } rsp_t;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*4-1:0] req_op;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [N*W-1:0] rsp_f;
    logic [N-1:0]   rsp_ovf;
    logic [N-1:0]   rsp_branch;
    logic [N-1:0]   rsp_illegal;
    logic [7:0]     illegal_cnt;

    int   n_checks = 0;
    int   n_fail   = 0;
    rsp_t q0[$];
    rsp_t q1[$];
    int   exp_ptr  = 0;
    int   exp_cnt  = 0;

    alu_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_f       (rsp_f),
        .rsp_ovf     (rsp_ovf),
        .rsp_branch  (rsp_branch),
        .rsp_illegal (rsp_illegal),
        .illegal_cnt (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rsp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        rsp_t        r;
        logic [16:0] s;
        logic [15:0] t;
        r = '0;
        case (op)
            4'd0: begin
                s     = {a[15], a} + {b[15], b};
                r.f   = s[15:0];
                r.ovf = s[16] ^ s[15];
            end
            4'd1: r.f = ~a;
            4'd2: r.f = a & b;
            4'd3: r.f = a | b;
            4'd4: begin
                t = a;
                for (int n = 0; n < 16; n++) if (n < int'(b)) t = {t[15], t[15:1]};
                r.f = t;
            end
            4'd5: r.f = (b >= 16'd16) ? 16'h0 : (a << b[3:0]);
            4'd6: r.br = (a == 16'h0);
            4'd7: r.br = (a != 16'h0);
            4'd8: r.f = a ^ b;
            default: r.ill = 1'b1;
        endcase
        return r;
    endfunction

    task automatic set_req(input int i, input logic v, input logic [3:0] op,
                           input logic [15:0] a, input logic [15:0] b);
        req_valid[i]      = v;
        req_op[i*4 +: 4]  = op;
        req_a[i*W +: W]   = a;
        req_b[i*W +: W]   = b;
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    // One clock cycle: check handshake/outputs against the model, pop
    // consumed results, push newly granted ones, then advance to the next negedge.
    task automatic step(output logic [1:0] g);
        logic [1:0] elig;
        rsp_t       e;
        int         idx;
        #1;
        for (int i = 0; i < N; i++)
            elig[i] = req_valid[i] && (qsize(i) == 0 || rsp_ready[i]);
        g = 2'b00;
        for (int k = 0; k < N; k++) begin
            idx = (exp_ptr + k) % N;
            if (g == 2'b00 && elig[idx]) g[idx] = 1'b1;
        end
        check("req_ready", {30'd0, req_ready}, {30'd0, g});
        for (int i = 0; i < N; i++) begin
            check($sformatf("rsp_valid%0d", i), {31'd0, rsp_valid[i]}, {31'd0, qsize(i) != 0});
            if (qsize(i) != 0 && rsp_ready[i]) begin
                e = (i == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("rsp_f%0d", i), {16'd0, rsp_f[i*W +: W]}, {16'd0, e.f});
                check($sformatf("rsp_ovf%0d", i), {31'd0, rsp_ovf[i]}, {31'd0, e.ovf});
                check($sformatf("rsp_branch%0d", i), {31'd0, rsp_branch[i]}, {31'd0, e.br});
                check($sformatf("rsp_illegal%0d", i), {31'd0, rsp_illegal[i]}, {31'd0, e.ill});
            end
        end
        for (int i = 0; i < N; i++) begin
            if (g[i]) begin
                e = model(req_op[i*4 +: 4], req_a[i*W +: W], req_b[i*W +: W]);
                if (i == 0) q0.push_back(e); else q1.push_back(e);
                if (e.ill && exp_cnt < 255) exp_cnt++;
                exp_ptr = (i + 1) % N;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [3:0]  t_op [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd0};
    logic [15:0] t_a  [8] = '{16'h8000, 16'h00F0, 16'hF0F0, 16'h1200, 16'h8000, 16'h0001, 16'hAAAA, 16'h1234};
    logic [15:0] t_b  [8] = '{16'h8000, 16'h0000, 16'h3C3C, 16'h0034, 16'h0004, 16'h000F, 16'h5555, 16'h4321};

    initial begin
        logic [1:0] g;
        int         n0;
        int         n1;

        rst = 1'b1;
        req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = '0;
        set_req(0, 1'b1, 4'd0, 16'h1, 16'h1);
        set_req(1, 1'b1, 4'd0, 16'h2, 16'h2);
        repeat (2) @(negedge clk);
        #1;
        check("reset req_ready", {30'd0, req_ready}, 32'd0);
        check("reset rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("reset illegal_cnt", {24'd0, illegal_cnt}, 32'd0);
        check("reset rsp_f", rsp_f, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;

        // ADD overflow into sign bit
        set_req(0, 1'b1, 4'd0, 16'h7FFF, 16'h0001);
        rsp_ready = 2'b00;
        step(g);
        check("add rsp_valid0", {31'd0, rsp_valid[0]}, 32'd1);
        check("add rsp_f0", {16'd0, rsp_f[15:0]}, 32'h8000);
        check("add rsp_ovf0", {31'd0, rsp_ovf[0]}, 32'd1);
        check("add rsp_branch0", {31'd0, rsp_branch[0]}, 32'd0);
        req_valid = '0;
        rsp_ready = 2'b01;
        step(g);

        // Both requesters streaming, responses always consumed
        n0 = 0; n1 = 0;
        rsp_ready = 2'b11;
        for (int k = 0; k < 12; k++) begin
            set_req(0, 1'b1, t_op[n0 % 8], t_a[n0 % 8], t_b[n0 % 8]);
            set_req(1, 1'b1, t_op[(n1 + 3) % 8], t_a[(n1 + 5) % 8], t_b[(n1 + 3) % 8]);
            step(g);
            check("alternating grant", {31'd0, g[0]}, {31'd0, (k % 2) == 1});
            if (g[0]) n0++;
            if (g[1]) n1++;
        end
        req_valid = '0;
        step(g);

        // BEQ result held while requester 1 stalls its response
        set_req(1, 1'b1, 4'd6, 16'h0000, 16'h0005);
        rsp_ready = 2'b00;
        step(g);
        for (int k = 0; k < 3; k++) begin
            set_req(0, 1'b1, 4'd0, 16'(k), 16'h0010);
            set_req(1, 1'b1, 4'd7, 16'h0003, 16'h0000);
            rsp_ready = 2'b01;
            step(g);
            check("held rsp_branch1", {31'd0, rsp_branch[1]}, 32'd1);
            check("held rsp_valid1", {31'd0, rsp_valid[1]}, 32'd1);
            check("held rsp_f1", {16'd0, rsp_f[31:16]}, 32'd0);
        end
        req_valid[0] = 1'b0;
        rsp_ready = 2'b11;
        step(g);
        req_valid = '0;
        step(g);

        // Illegal op masking and saturating counter
        set_req(0, 1'b1, 4'hF, 16'h1234, 16'h0001);
        rsp_ready = 2'b00;
        step(g);
        check("ill rsp_illegal0", {31'd0, rsp_illegal[0]}, 32'd1);
        check("ill rsp_ovf0", {31'd0, rsp_ovf[0]}, 32'd0);
        check("ill rsp_branch0", {31'd0, rsp_branch[0]}, 32'd0);
        check("ill rsp_f0", {16'd0, rsp_f[15:0]}, 32'd0);
        check("ill illegal_cnt", {24'd0, illegal_cnt}, 32'd1);
        rsp_ready = 2'b01;
        for (int k = 0; k < 299; k++) begin
            set_req(0, 1'b1, 4'(9 + (k % 7)), 16'(k), 16'h0001);
            step(g);
            check("illegal_cnt", {24'd0, illegal_cnt}, exp_cnt);
        end
        check("illegal_cnt sat", {24'd0, illegal_cnt}, 32'd255);
        req_valid = '0;
        rsp_ready = 2'b00;
        step(g);

        // Asynchronous reset with slot 0 full and rr_ptr at 1
        set_req(0, 1'b1, 4'd0, 16'h1, 16'h1);
        set_req(1, 1'b1, 4'd0, 16'h2, 16'h2);
        #2;
        rst = 1'b1;
        #1;
        check("async rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("async illegal_cnt", {24'd0, illegal_cnt}, 32'd0);
        check("async req_ready", {30'd0, req_ready}, 32'd0);
        q0.delete(); q1.delete();
        exp_ptr = 0; exp_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 2'b11;
        step(g);
        check("rr_ptr after reset", {30'd0, g}, 32'd1);
        req_valid = '0;
        step(g);
        step(g);

        // Pass-through refill with no bubble
        set_req(0, 1'b1, 4'd0, 16'h0001, 16'h0002);
        rsp_ready = 2'b00;
        step(g);
        set_req(0, 1'b1, 4'd8, 16'h00FF, 16'h0F0F);
        rsp_ready = 2'b01;
        step(g);
        check("refill rsp_valid0", {31'd0, rsp_valid[0]}, 32'd1);
        check("refill rsp_f0", {16'd0, rsp_f[15:0]}, 32'h0FF0);
        req_valid = '0;
        rsp_ready = 2'b11;
        step(g);
        step(g);
        check("scoreboard empty", q0.size() + q1.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
